imem_loadable: RTL and testbench

- Parametrised, synchronous successor to the fixed combinational instruction ROM of the MIPS datapath.
- Program RAM that is written at runtime through a streaming load port (valid/ready), then serves IF-stage fetches with a registered read of 1-cycle latency and pipeline stall hold.
- Sits between the PC register and the IF/ID pipeline register. The loader is driven by the testbench or a host/UART block.

---
 rtl/imem_loadable.sv | 106 ++++++++++
 tb/tb_imem_loadable.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// imem_loadable: loadable program RAM with streaming load port and 1-cycle registered IF fetch (optional IMEM_MISALIGN_TRAP_EN traps misaligned fetches)
module imem_loadable #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_start,
  input  logic                     ld_valid,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic                     ld_done,
  output logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     fetch_en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     stall,
  output logic [DATA_W-1:0]        instr,
  output logic                     instr_valid,
  output logic                     oob_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {RUN, LOAD} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0] prog_len_q, prog_len_d;
  logic ld_done_q, ld_done_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic instr_valid_q, instr_valid_d;
  logic oob_err_q, oob_err_d;
  logic we;
  logic bad;
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};
  wire [AW-1:0] ridx = addr[AW+1:2];
  wire in_range = addr[ADDR_W-1:AW+2] == '0;
`ifdef IMEM_MISALIGN_TRAP_EN
  assign bad = !in_range || (addr[1:0] != 2'b00);
`else
  logic unused_lsb;
  assign unused_lsb = ^addr[1:0];
  assign bad = !in_range;
`endif
  always_comb begin
    state_d = state_q;
    wptr_d = wptr_q;
    prog_len_d = prog_len_q;
    ld_done_d = 1'b0;
    instr_d = instr_q;
    instr_valid_d = instr_valid_q;
    oob_err_d = oob_err_q;
    we = 1'b0;
    if (state_q == RUN) begin
      if (ld_start) begin
        state_d = LOAD;
        wptr_d = '0;
        instr_valid_d = 1'b0;
        oob_err_d = 1'b0;
      end else if (!stall) begin
        instr_valid_d = fetch_en;
        oob_err_d = fetch_en & bad;
        instr_d = !fetch_en ? instr_q : bad ? NOP_WORD : mem[ridx];
      end
    end else begin
      instr_valid_d = 1'b0;
      oob_err_d = 1'b0;
      if (ld_start) wptr_d = '0;
      else if (ld_valid) begin
        we = 1'b1;
        wptr_d = wptr_q + 1'b1;
        if (ld_last || wptr_q == AW'(DEPTH - 1)) begin
          prog_len_d = {1'b0, wptr_q} + 1'b1;
          ld_done_d = 1'b1;
          state_d = RUN;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wptr_q <= '0;
      prog_len_q <= '0;
      ld_done_q <= 1'b0;
      instr_q <= NOP_WORD;
      instr_valid_q <= 1'b0;
      oob_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      prog_len_q <= prog_len_d;
      ld_done_q <= ld_done_d;
      instr_q <= instr_d;
      instr_valid_q <= instr_valid_d;
      oob_err_q <= oob_err_d;
    end
  end
  always_ff @(posedge clk) if (we) mem[wptr_q] <= ld_data;
  assign ld_ready = state_q == LOAD;
  assign ld_done = ld_done_q;
  assign prog_len = prog_len_q;
  assign instr = instr_q;
  assign instr_valid = instr_valid_q;
  assign oob_err = oob_err_q;
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: self-checking bench for imem_loadable against a word-array reference model
module tb_imem_loadable;
  localparam int DEPTH = 64;
`ifdef IMEM_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic fetch_en = 1'b0, stall = 1'b0;
  logic [31:0] ld_data = '0, addr = '0;
  logic ld_ready, ld_done, instr_valid, oob_err;
  logic [6:0] prog_len;
  logic [31:0] instr;
  int checks = 0, errors = 0;
  logic [31:0] mm [DEPTH];
  logic [31:0] m_i;
  logic m_v, m_o;
  typedef struct {
    logic fe;
    logic st;
    logic [31:0] a;
    logic [31:0] ei;
    logic ev;
    logic eo;
  } vec_t;
  vec_t vt [11];
  imem_loadable dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_done(ld_done), .prog_len(prog_len),
    .fetch_en(fetch_en), .addr(addr), .stall(stall), .instr(instr),
    .instr_valid(instr_valid), .oob_err(oob_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic check_out(input string nm);
    check({nm, ".instr"}, instr, m_i);
    check({nm, ".valid"}, {31'b0, instr_valid}, {31'b0, m_v});
    check({nm, ".oob"}, {31'b0, oob_err}, {31'b0, m_o});
  endtask
  task automatic load(input int n, input bit use_last, input bit rnd);
    int i = 0;
    logic v;
    logic [31:0] d;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    m_v = 1'b0;
    m_o = 1'b0;
    check("load.ready_after_start", {31'b0, ld_ready}, 32'd1);
    while (i < n) begin
      v = $urandom_range(0, 3) != 0;
      d = rnd ? $urandom : 32'h2008_0020 + 32'(i) * 32'h0001_0007;
      ld_valid = v;
      ld_data = d;
      ld_last = use_last && i == n - 1;
      tick();
      if (v) begin
        mm[i] = d;
        i++;
      end
      if (i < n) check("load.ready_mid", {31'b0, ld_ready}, 32'd1);
    end
    ld_valid = 1'b0;
    ld_last = 1'b0;
    check("load.done", {31'b0, ld_done}, 32'd1);
    check("load.ready_drop", {31'b0, ld_ready}, 32'd0);
    check("load.prog_len", {25'b0, prog_len}, 32'(n));
    check("load.valid_off", {31'b0, instr_valid}, 32'd0);
    tick();
    check("load.done_pulse", {31'b0, ld_done}, 32'd0);
  endtask
  task automatic fetch(input logic fe, input logic st, input logic [31:0] a, input string nm);
    logic bad;
    fetch_en = fe;
    stall = st;
    addr = a;
    tick();
    if (!st) begin
      bad = (a >> 2) >= DEPTH || (MIS && a[1:0] != 2'b00);
      m_v = fe;
      m_o = fe && bad;
      if (fe) m_i = bad ? 32'h0 : mm[(a >> 2) % DEPTH];
    end
    check_out(nm);
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
    m_i = 32'h0;
    m_v = 1'b0;
    m_o = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_out("reset");
    check("reset.ready", {31'b0, ld_ready}, 32'd0);
    check("reset.done", {31'b0, ld_done}, 32'd0);
    check("reset.prog_len", {25'b0, prog_len}, 32'd0);
    load(30, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) fetch(1'b1, 1'b0, 32'(i) << 2, "prog1");
    load(DEPTH, 1'b0, 1'b1);
    ld_valid = 1'b1;
    ld_data = 32'hFFFF_FFFF;
    tick();
    ld_valid = 1'b0;
    check("full.no_ready", {31'b0, ld_ready}, 32'd0);
    check("full.no_done", {31'b0, ld_done}, 32'd0);
    check("full.prog_len", {25'b0, prog_len}, 32'd64);
    vt[0] = '{1'b1, 1'b0, 32'h8, mm[2], 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b1, 32'hC, mm[2], 1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'hC, mm[2], 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b1, 32'hC, mm[2], 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b0, 32'hC, mm[3], 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1};
    vt[6] = '{1'b1, 1'b0, 32'hFC, mm[63], 1'b1, 1'b0};
    vt[7] = '{1'b1, 1'b0, 32'h6, MIS ? 32'h0 : mm[1], 1'b1, MIS};
    vt[8] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1};
    vt[9] = '{1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1};
    vt[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    foreach (vt[i]) begin
      fetch_en = vt[i].fe;
      stall = vt[i].st;
      addr = vt[i].a;
      tick();
      m_i = vt[i].ei;
      m_v = vt[i].ev;
      m_o = vt[i].eo;
      check_out($sformatf("vec%0d", i));
    end
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 32'h13F);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      fetch($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, a, "rand");
      check("rand.ready", {31'b0, ld_ready}, 32'd0);
    end
    fetch(1'b1, 1'b0, 32'h0, "pre_start");
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    fetch_en = 1'b0;
    check("start.drop_fetch", {31'b0, instr_valid}, 32'd0);
    check("start.ready", {31'b0, ld_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data = 32'hB000_0000 + 32'(i);
      tick();
      mm[i] = ld_data;
    end
    ld_start = 1'b1;
    ld_data = 32'hDEAD_BEEF;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_data = 32'hA000_0000 + 32'(i);
      tick();
      mm[i] = ld_data;
    end
    ld_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_i = 32'h0;
    m_v = 1'b0;
    m_o = 1'b0;
    check_out("midreset");
    check("midreset.ready", {31'b0, ld_ready}, 32'd0);
    check("midreset.prog_len", {25'b0, prog_len}, 32'd0);
    check("midreset.done", {31'b0, ld_done}, 32'd0);
    for (int i = 0; i < 8; i++) fetch(1'b1, 1'b0, 32'(i) << 2, "retained");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
